// File: rtl/insn_buffer_pkg.sv
// ProcessorTypes: types shared by fetch, the instruction buffer and decode.
//   insn_entry_t            - one 16-bit instruction parcel with its pc and fault flag
//   INSN_BUFFER_ENTRY_COUNT - default number of parcel slots in insn_buffer
package ProcessorTypes;

    localparam int INSN_BUFFER_ENTRY_COUNT = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic        fault;
        logic [15:0] insn;
    } insn_entry_t;

endpackage

// File: rtl/insn_buffer_if.sv
// InsnBufferIF: bundle between fetch, insn_buffer and decode.
//   fetch  - drives writeLow/writeHigh and the parcels, sees free slot count
//   decode - sees the two oldest parcels and occupancy, drives readCount
//   buffer - the insn_buffer side of both
interface InsnBufferIF #(
    parameter int ENTRY_COUNT = ProcessorTypes::INSN_BUFFER_ENTRY_COUNT
);
    import ProcessorTypes::*;

    logic                           flush;
    logic                           writeLow;
    logic                           writeHigh;
    insn_entry_t                    writeEntryLow;
    insn_entry_t                    writeEntryHigh;
    logic [$clog2(ENTRY_COUNT):0]   writableEntryCount;
    logic [$clog2(ENTRY_COUNT):0]   readableEntryCount;
    insn_entry_t                    readEntryLow;
    insn_entry_t                    readEntryHigh;
    logic [1:0]                     readCount;

    modport fetch (
        output writeLow, writeHigh, writeEntryLow, writeEntryHigh,
        input  writableEntryCount
    );

    modport decode (
        input  readableEntryCount, readEntryLow, readEntryHigh,
        output readCount
    );

    modport buffer (
        input  flush, writeLow, writeHigh, writeEntryLow, writeEntryHigh, readCount,
        output writableEntryCount, readableEntryCount, readEntryLow, readEntryHigh
    );

endinterface

// File: rtl/insn_buffer.sv
// insn_buffer: circular buffer of 16-bit instruction parcels between fetch and decode.
// Up to two parcels pushed (Low then High) and up to two popped per cycle.
//   clk, rst                          - clock, asynchronous active-high reset
//   flush                             - discard all contents at the edge
//   writeLow/writeHigh                - push writeEntryLow / writeEntryHigh
//   writableEntryCount                - free slots (registered)
//   readableEntryCount                - occupied slots (registered)
//   readEntryLow/readEntryHigh        - oldest / second-oldest parcel
//   readCount                         - parcels popped this cycle (0..2)
// Build option: define INSN_BUFFER_FAULT_EN to store the per-parcel fault bit;
// otherwise the read fault fields are constant 0.
module insn_buffer
    import ProcessorTypes::*;
#(
    parameter int ENTRY_COUNT = INSN_BUFFER_ENTRY_COUNT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           writeLow,
    input  logic                           writeHigh,
    input  insn_entry_t                    writeEntryLow,
    input  insn_entry_t                    writeEntryHigh,
    output logic [$clog2(ENTRY_COUNT):0]   writableEntryCount,
    output logic [$clog2(ENTRY_COUNT):0]   readableEntryCount,
    output insn_entry_t                    readEntryLow,
    output insn_entry_t                    readEntryHigh,
    input  logic [1:0]                     readCount
);

    localparam int PW = $clog2(ENTRY_COUNT);
    localparam int CW = PW + 1;

    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic [CW-1:0] occ;

    logic [31:0]   pc_mem   [ENTRY_COUNT];
    logic [15:0]   insn_mem [ENTRY_COUNT];

    logic [1:0]    push_cnt;
    logic [CW-1:0] free_cnt;
    logic          do_push;
    logic          do_pop;
    logic [1:0]    pop_cnt;
    logic [PW-1:0] wp_high;
    logic [PW-1:0] rp_high;

    assign push_cnt = {1'b0, writeLow} + {1'b0, writeHigh};
    assign free_cnt = CW'(ENTRY_COUNT) - occ;

    // Both checks use start-of-cycle occupancy: a push cannot use slots freed by
    // a same-cycle pop, and a pop cannot reach a same-cycle push. An oversized
    // request is dropped whole; readCount of 3 is never legal.
    assign do_push = !flush && (push_cnt != 2'd0) && (CW'(push_cnt) <= free_cnt);
    assign do_pop  = !flush && (readCount != 2'd3) && (CW'(readCount) <= occ);
    assign pop_cnt = do_pop ? readCount : 2'd0;

    // High goes to wp+1 only when Low is pushed alongside it.
    assign wp_high = writeLow ? wp + PW'(1) : wp;
    assign rp_high = rp + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp  <= '0;
            wp  <= '0;
            occ <= '0;
        end else if (flush) begin
            rp  <= '0;
            wp  <= '0;
            occ <= '0;
        end else begin
            rp  <= rp + PW'(pop_cnt);
            wp  <= wp + (do_push ? PW'(push_cnt) : PW'(0));
            occ <= occ + (do_push ? CW'(push_cnt) : CW'(0)) - CW'(pop_cnt);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            if (writeLow) begin
                pc_mem[wp]   <= writeEntryLow.pc;
                insn_mem[wp] <= writeEntryLow.insn;
            end
            if (writeHigh) begin
                pc_mem[wp_high]   <= writeEntryHigh.pc;
                insn_mem[wp_high] <= writeEntryHigh.insn;
            end
        end
    end

`ifdef INSN_BUFFER_FAULT_EN
    logic fault_mem [ENTRY_COUNT];

    always_ff @(posedge clk) begin
        if (do_push) begin
            if (writeLow) begin
                fault_mem[wp] <= writeEntryLow.fault;
            end
            if (writeHigh) begin
                fault_mem[wp_high] <= writeEntryHigh.fault;
            end
        end
    end

    logic fault_low;
    logic fault_high;
    assign fault_low  = fault_mem[rp];
    assign fault_high = fault_mem[rp_high];
`else
    logic fault_low;
    logic fault_high;
    logic unused_fault;
    assign fault_low    = 1'b0;
    assign fault_high   = 1'b0;
    assign unused_fault = writeEntryLow.fault ^ writeEntryHigh.fault;
`endif

    always_comb begin
        readEntryLow       = '0;
        readEntryHigh      = '0;
        readEntryLow.pc    = pc_mem[rp];
        readEntryLow.insn  = insn_mem[rp];
        readEntryLow.fault = fault_low;
        readEntryHigh.pc    = pc_mem[rp_high];
        readEntryHigh.insn  = insn_mem[rp_high];
        readEntryHigh.fault = fault_high;
    end

    assign readableEntryCount = occ;
    assign writableEntryCount = free_cnt;

endmodule

// File: tb/tb_insn_buffer.sv
module tb_insn_buffer;
    import ProcessorTypes::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        writeLow = 1'b0;
    logic        writeHigh = 1'b0;
    insn_entry_t writeEntryLow = '0;
    insn_entry_t writeEntryHigh = '0;
    logic [3:0]  writableEntryCount;
    logic [3:0]  readableEntryCount;
    insn_entry_t readEntryLow;
    insn_entry_t readEntryHigh;
    logic [1:0]  readCount = 2'd0;

    int n_tests = 0;
    int n_fail  = 0;

    insn_buffer #(.ENTRY_COUNT(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .writeLow           (writeLow),
        .writeHigh          (writeHigh),
        .writeEntryLow      (writeEntryLow),
        .writeEntryHigh     (writeEntryHigh),
        .writableEntryCount (writableEntryCount),
        .readableEntryCount (readableEntryCount),
        .readEntryLow       (readEntryLow),
        .readEntryHigh      (readEntryHigh),
        .readCount          (readCount)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, sample 1 time unit after the edge, return to idle.
    task automatic step(input logic wl, input logic wh, input logic [31:0] pcl,
                        input logic [31:0] pch, input logic [1:0] rc, input logic fl,
                        input logic fault_h);
        writeLow            = wl;
        writeHigh           = wh;
        writeEntryLow.pc    = pcl;
        writeEntryLow.insn  = pcl[15:0] ^ 16'hA5A5;
        writeEntryLow.fault = 1'b0;
        writeEntryHigh.pc   = pch;
        writeEntryHigh.insn = pch[15:0] ^ 16'hA5A5;
        writeEntryHigh.fault = fault_h;
        readCount           = rc;
        flush               = fl;
        @(posedge clk);
        #1;
        writeLow  = 1'b0;
        writeHigh = 1'b0;
        readCount = 2'd0;
        flush     = 1'b0;
        writeEntryHigh.fault = 1'b0;
    endtask

    initial begin
        #12;
        check_val("rst_writable", 32'(writableEntryCount), 32'd8);
        check_val("rst_readable", 32'(readableEntryCount), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // two parcels in one cycle
        step(1, 1, 32'h100, 32'h102, 2'd0, 0, 0);
        check_val("pair_readable", 32'(readableEntryCount), 32'd2);
        check_val("pair_writable", 32'(writableEntryCount), 32'd6);
        check_val("pair_low_pc",   readEntryLow.pc, 32'h100);
        check_val("pair_high_pc",  readEntryHigh.pc, 32'h102);
        check_val("pair_low_insn", 32'(readEntryLow.insn), 32'h0000A4A5);

        // fill to full, then a push while full is dropped but the pop happens
        step(1, 1, 32'h104, 32'h106, 2'd0, 0, 0);
        step(1, 1, 32'h108, 32'h10a, 2'd0, 0, 0);
        step(1, 1, 32'h10c, 32'h10e, 2'd0, 0, 0);
        check_val("full_writable", 32'(writableEntryCount), 32'd0);
        check_val("full_readable", 32'(readableEntryCount), 32'd8);
        step(1, 1, 32'h1f0, 32'h1f2, 2'd2, 0, 0);
        check_val("drop_readable", 32'(readableEntryCount), 32'd6);
        check_val("drop_writable", 32'(writableEntryCount), 32'd2);
        check_val("drop_low_pc",   readEntryLow.pc, 32'h104);
        check_val("drop_high_pc",  readEntryHigh.pc, 32'h106);

        // walk rp to 6 with occupancy 3 (slots 6,7,0)
        step(0, 0, 0, 0, 2'd2, 0, 0);
        step(0, 0, 0, 0, 2'd2, 0, 0);
        step(1, 0, 32'h120, 0, 2'd0, 0, 0);
        check_val("pre_wrap_readable", 32'(readableEntryCount), 32'd3);
        check_val("pre_wrap_low_pc",   readEntryLow.pc, 32'h10c);
        check_val("pre_wrap_high_pc",  readEntryHigh.pc, 32'h10e);

        // push 2 and pop 1 together across the wrap
        step(1, 1, 32'h122, 32'h124, 2'd1, 0, 0);
        check_val("wrap_readable", 32'(readableEntryCount), 32'd4);
        check_val("wrap_low_pc",   readEntryLow.pc, 32'h10e);
        check_val("wrap_high_pc",  readEntryHigh.pc, 32'h120);
        step(0, 0, 0, 0, 2'd2, 0, 0);
        check_val("wrap2_low_pc",  readEntryLow.pc, 32'h122);
        check_val("wrap2_high_pc", readEntryHigh.pc, 32'h124);

        // pop more than readable is ignored
        step(0, 0, 0, 0, 2'd1, 0, 0);
        check_val("one_left_readable", 32'(readableEntryCount), 32'd1);
        step(0, 0, 0, 0, 2'd2, 0, 0);
        check_val("overpop_readable", 32'(readableEntryCount), 32'd1);
        check_val("overpop_low_pc",   readEntryLow.pc, 32'h124);

        // flush wins over same-cycle push and pop
        step(1, 1, 32'h130, 32'h132, 2'd0, 0, 0);
        step(1, 1, 32'h134, 32'h136, 2'd0, 0, 0);
        check_val("pre_flush_readable", 32'(readableEntryCount), 32'd5);
        step(1, 1, 32'h140, 32'h142, 2'd2, 1, 0);
        check_val("flush_readable", 32'(readableEntryCount), 32'd0);
        check_val("flush_writable", 32'(writableEntryCount), 32'd8);

        // high-only push lands in the oldest slot; fault bit follows the build option
        step(0, 1, 0, 32'h202, 2'd0, 0, 1);
        check_val("hi_only_readable", 32'(readableEntryCount), 32'd1);
        check_val("hi_only_low_pc",   readEntryLow.pc, 32'h202);
`ifdef INSN_BUFFER_FAULT_EN
        check_val("fault_low", 32'(readEntryLow.fault), 32'd1);
`else
        check_val("fault_low", 32'(readEntryLow.fault), 32'd0);
`endif

        // asynchronous reset mid-operation empties without a clock edge
        step(1, 1, 32'h300, 32'h302, 2'd0, 0, 0);
        check_val("pre_rst_readable", 32'(readableEntryCount), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_readable", 32'(readableEntryCount), 32'd0);
        check_val("async_rst_writable", 32'(writableEntryCount), 32'd8);
        @(negedge clk);
        rst = 1'b0;

        // first push after reset is readable one cycle later
        step(1, 0, 32'h400, 0, 2'd0, 0, 0);
        check_val("post_rst_low_pc",   readEntryLow.pc, 32'h400);
        check_val("post_rst_readable", 32'(readableEntryCount), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
